// File: rtl/useq_pkg.sv
// Shared definitions for the micro-sequencer: p-field branch encodings and
// the run/halt state type.
package useq_pkg;

    typedef enum logic [3:0] {
        P_SEQ    = 4'd0,
        P_IROP   = 4'd1,
        P_IRMODE = 4'd2,
        P_SW     = 4'd3,
        P_JZ     = 4'd4,
        P_JC     = 4'd5,
        P_CALL   = 4'd6,
        P_RET    = 4'd7,
        P_HALT   = 4'd8
    } p_field_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } seq_state_e;

endpackage

// File: rtl/useq_stack.sv
// LIFO return-address stack for micro-calls. The top entry is presented
// combinationally; push on full and pop on empty are ignored.
module useq_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int SLOTS = 1 << PTR_W;

    logic [WIDTH-1:0] mem [SLOTS];
    logic [PTR_W-1:0] sp;
    logic [PTR_W-1:0] top_idx;

    assign full    = (sp == PTR_W'(DEPTH));
    assign empty   = (sp == '0);
    assign top_idx = sp - PTR_W'(1);
    assign top     = mem[top_idx];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + PTR_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - PTR_W'(1);
        end
    end

    // NOTE: storage has no reset; only the pointer does, so entries are never
    // read before being written.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[sp] <= din;
        end
    end

endmodule

// File: rtl/useq_ctrl.sv
// Micro-sequencer: one-hot phase generator plus micro-address register that
// steps once per micro-cycle, with branch, call/return and halt support.
module useq_ctrl
    import useq_pkg::*;
#(
    parameter int               PHASES      = 2,
    parameter int               UA_W        = 8,
    parameter int               STACK_DEPTH = 4,
    parameter logic [UA_W-1:0]  RESET_UA    = '0
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              run,
    input  logic              resume,
    input  logic [UA_W-1:0]   ua,
    input  logic [3:0]        p,
    input  logic [15:0]       ir,
    input  logic              swa,
    input  logic              swb,
    input  logic              flag_z,
    input  logic              flag_c,
    output logic [PHASES-1:0] phase,
    output logic [UA_W-1:0]   uaddr,
    output logic              halted,
    output logic              stk_ovf,
    output logic              stk_unf
);

    seq_state_e        state_q, state_d;
    logic [UA_W-1:0]   uaddr_inc;
    logic [UA_W-1:0]   nxt_uaddr;
    logic              boundary;
    logic              push, pop, halt_req, ovf_set, unf_set;
    logic [UA_W-1:0]   stk_top;
    logic              stk_full, stk_empty;
    logic              unused_ir;

    assign unused_ir = ^ir[9:0];
    assign uaddr_inc = uaddr + UA_W'(1);
    assign halted    = (state_q == ST_HALT);
    // The boundary is the edge that wraps the last phase back to the first.
    assign boundary  = run && (state_q == ST_RUN) && phase[PHASES-1];

    // NOTE: every always_comb output gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        nxt_uaddr = ua;
        push      = 1'b0;
        pop       = 1'b0;
        halt_req  = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        case (p)
            P_IROP:   nxt_uaddr[3:0] = ua[3:0] | ir[15:12];
            P_IRMODE: nxt_uaddr[1:0] = ua[1:0] | ir[11:10];
            P_SW:     nxt_uaddr[1:0] = ua[1:0] | {swb, swa};
            P_JZ:     nxt_uaddr = flag_z ? ua : uaddr_inc;
            P_JC:     nxt_uaddr = flag_c ? ua : uaddr_inc;
            P_CALL: begin
                push    = boundary && !stk_full;
                ovf_set = boundary && stk_full;
            end
            P_RET: begin
                nxt_uaddr = stk_empty ? RESET_UA : stk_top;
                pop       = boundary && !stk_empty;
                unf_set   = boundary && stk_empty;
            end
            P_HALT: begin
                nxt_uaddr = uaddr;
                halt_req  = 1'b1;
            end
            default:  nxt_uaddr = ua;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (boundary && halt_req) state_d = ST_HALT;
            ST_HALT: if (resume)               state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_RUN;
            phase   <= PHASES'(1);
            uaddr   <= RESET_UA;
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
        end else begin
            state_q <= state_d;
            if (run && (state_q == ST_RUN)) begin
                phase <= {phase[PHASES-2:0], phase[PHASES-1]};
            end
            if (boundary) begin
                uaddr <= nxt_uaddr;
            end else if (halted && resume) begin
                uaddr <= uaddr_inc;
            end
            stk_ovf <= stk_ovf | ovf_set;
            stk_unf <= stk_unf | unf_set;
        end
    end

    useq_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (UA_W)
    ) u_stack (
        .clk   (clk),
        .clr_n (clr_n),
        .push  (push),
        .pop   (pop),
        .din   (uaddr_inc),
        .top   (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

endmodule

// File: doc/useq_ctrl.md
USEQ_CTRL -- requirements
Module: useq_ctrl

Interface
REQ-001 Parameter PHASES, default 2, number of clock phases per micro-cycle (2..8).
REQ-002 Parameter UA_W, default 8, micro-address width.
REQ-003 Parameter STACK_DEPTH, default 4, micro-call return stack entries (1..16).
REQ-004 Parameter RESET_UA, default 0, micro-address loaded on reset.
REQ-005 clk  in  1  sole clock, rising-edge.
REQ-006 clr_n  in  1  asynchronous active-low reset.
REQ-007 run  in  1  phase-counter enable; 0 freezes sequencing.
REQ-008 resume  in  1  single-cycle pulse releasing HALT.
REQ-009 ua  in  UA_W  next-address field of current microword.
REQ-010 p  in  4  branch/test field of current microword.
REQ-011 ir  in  16  instruction register contents.
REQ-012 swa, swb  in  1 each  console mode switches.
REQ-013 flag_z, flag_c  in  1 each  zero/carry status.
REQ-014 phase  out  PHASES  one-hot phase; bit 0 = generate phase, bit PHASES-1 = execute phase.
REQ-015 uaddr  out  UA_W  current micro-address to control store.
REQ-016 halted  out  1  HALT microword reached.
REQ-017 stk_ovf, stk_unf  out  1 each  sticky stack error flags.

Function
REQ-018 Phase SHALL advance one position per clk while run=1 and halted=0, wrapping PHASES-1 -> 0.
REQ-019 uaddr SHALL update only on the clk edge that wraps phase from PHASES-1 to 0 (the "boundary"); latency one micro-cycle.
REQ-020 run=0 SHALL freeze phase and uaddr; no boundary occurs; stack and flags hold.
REQ-021 Next address at boundary by p: 0 = ua; 1 = ua with low 4 bits ORed by ir[15:12]; 2 = ua low 2 bits ORed by ir[11:10]; 3 = ua low 2 bits ORed by {swb,swa}.
REQ-022 p=4 (JZ): flag_z ? ua : uaddr+1; p=5 (JC): flag_c ? ua : uaddr+1; uaddr+1 wraps modulo 2^UA_W.
REQ-023 p=6 (CALL): push uaddr+1, next = ua; if stack full, push discarded, stk_ovf set, next still ua.
REQ-024 p=7 (RET): next = popped entry; if stack empty, stk_unf set, next = RESET_UA.
REQ-025 p=8 (HALT): uaddr holds, halted set at boundary, phase parks at bit 0.
REQ-026 p=9..15 SHALL behave as p=0.
REQ-027 While halted, resume=1 SHALL clear halted on that clk and load uaddr+1; phase remains bit 0 and advances from the next clk if run=1.
REQ-028 resume while not halted SHALL be ignored.
REQ-029 Inputs ua, p, ir, flags SHALL be sampled only at the boundary edge.
REQ-030 stk_ovf/stk_unf SHALL remain set until reset.

Reset
REQ-031 clr_n=0 SHALL immediately force phase = one-hot bit 0, uaddr = RESET_UA, halted=0, stack pointer 0, stk_ovf=stk_unf=0.
REQ-032 Reset asserted mid-micro-cycle SHALL abandon the cycle; no partial update survives; first boundary after release occurs PHASES clks after release with run=1.

Structure
REQ-033 Shared package useq_pkg SHALL hold the p-field encoding constants (P_SEQ, P_IROP, P_IRMODE, P_SW, P_JZ, P_JC, P_CALL, P_RET, P_HALT).
REQ-034 Return stack SHALL be a sub-module useq_stack (parameterised depth/width, push/pop/full/empty).
REQ-035 Next-address selection SHALL be combinational, registered only at the boundary.

Verification
REQ-036 PHASES=2, run=1, p=0, ua=8'h05 -> uaddr=8'h05 after 2 clks; phase toggles 01,10,01.
REQ-037 p=1, ua=8'h10, ir=16'hA000 -> next uaddr=8'h1A; p=3, ua=8'h20, swb=1, swa=0 -> 8'h22.
REQ-038 p=4 flag_z=0 at uaddr=8'hFF -> uaddr wraps to 8'h00; flag_z=1, ua=8'h40 -> 8'h40.
REQ-039 STACK_DEPTH=2: CALL x3 then RET x3 -> third CALL sets stk_ovf, returns retrieve last two pushes, third RET sets stk_unf and uaddr=RESET_UA.
REQ-040 HALT at uaddr=8'h30 -> halted=1, uaddr held across 10 clks; resume pulse -> halted=0, uaddr=8'h31.
REQ-041 clr_n pulsed low during phase 1 after CALL -> all outputs at reset values asynchronously, stack empty afterwards.
